// File: rtl/lcd_bus_responder.sv
// -----------------------------------------------------------------------------
// lcd_bus_responder
//   Behavioural stand-in for an HD44780-style character LCD controller, seen
//   from the bus side. It registers the E/RS/RW/data_in bus once and uses the
//   falling edge of the registered E as its strobe. It decodes instructions and
//   holds a 128-byte DDRAM. A busy down-counter models the execution time of
//   each accepted write.
//
// Parameters
//   BUSY_CYCLES   busy time after an ordinary instruction or data write (>= 1)
//   CLEAR_CYCLES  busy time after clear display / return home (>= 128)
//
// Ports
//   clk           single clock, rising edge
//   reset_n       asynchronous active-low reset
//   E, RS, RW     bus enable, register select (0 instr/status, 1 data),
//                 read/not-write
//   data_in       write data from the driver
//   data_out      read data (status or DDRAM), 0x00 when not reading
//   data_oe       high while registered E=1 and RW=1
//   busy          busy flag
//   addr          DDRAM address counter
//   init_done     sticky; function set, display control, clear and entry mode
//                 have each been accepted
//   protocol_err  sticky; write or data read while busy, or instruction 0x00
// -----------------------------------------------------------------------------
module lcd_bus_responder #(
   parameter int BUSY_CYCLES  = 40,
   parameter int CLEAR_CYCLES = 1600
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       E,
   input  logic       RS,
   input  logic       RW,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       data_oe,
   output logic       busy,
   output logic [6:0] addr,
   output logic       init_done,
   output logic       protocol_err
);

   localparam int MAX_CYCLES = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EHIGH,
      ST_BUSY,
      ST_CLEARING
   } state_t;

   typedef enum logic [3:0] {
      OP_NULL,
      OP_CLEAR,
      OP_HOME,
      OP_ENTRY,
      OP_DISP,
      OP_SHIFT,
      OP_FUNC,
      OP_CGRAM,
      OP_DDRAM
   } op_t;

   // bus input stage
   logic       e_reg, e_prev_reg, rs_reg, rw_reg;
   logic [7:0] din_reg;

   // control state
   state_t     state_reg, state_next;
   logic [CW-1:0] cnt_reg;
   logic [6:0] addr_reg;
   logic       id_reg, s_reg;
   logic       disp_d_reg, disp_c_reg, disp_b_reg;
   logic       fn_dl_reg, fn_n_reg, fn_f_reg;
   logic [5:0] cgram_addr_reg;
   logic       seen_func_reg, seen_disp_reg, seen_clear_reg, seen_entry_reg;
   logic       init_done_reg, protocol_err_reg;
   logic       fill_active_reg;
   logic [6:0] fill_idx_reg;

   // DDRAM with a registered read port
   logic [7:0] ddram [0:127];
   logic [7:0] ram_q_reg;

   // decode
   op_t        op;
   logic       busy_int, e_rise, e_fall;
   logic       acc_instr, acc_data_wr, acc_data_rd;
   logic       start_clear, start_home, start_busy, err_now;
   logic [6:0] addr_step;
   logic       ram_we;
   logic [6:0] ram_waddr;
   logic [7:0] ram_wdata;

   // ---------------------------------------------------------------- bus stage
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         e_reg      <= 1'b0;
         e_prev_reg <= 1'b0;
         rs_reg     <= 1'b0;
         rw_reg     <= 1'b0;
         din_reg    <= 8'h00;
      end else begin
         e_reg      <= E;
         e_prev_reg <= e_reg;
         rs_reg     <= RS;
         rw_reg     <= RW;
         din_reg    <= data_in;
      end
   end

   // instruction class is given by the highest set bit
   always_comb begin
      op = OP_NULL;
      casez (din_reg)
         8'b1???????: op = OP_DDRAM;
         8'b01??????: op = OP_CGRAM;
         8'b001?????: op = OP_FUNC;
         8'b0001????: op = OP_SHIFT;
         8'b00001???: op = OP_DISP;
         8'b000001??: op = OP_ENTRY;
         8'b0000001?: op = OP_HOME;
         8'b00000001: op = OP_CLEAR;
         default:     op = OP_NULL;
      endcase
   end

   always_comb begin
      busy_int    = (state_reg == ST_BUSY) || (state_reg == ST_CLEARING);
      e_rise      = e_reg & ~e_prev_reg;
      e_fall      = ~e_reg & e_prev_reg;
      acc_instr   = e_fall & ~rw_reg & ~rs_reg & ~busy_int;
      acc_data_wr = e_fall & ~rw_reg &  rs_reg & ~busy_int;
      acc_data_rd = e_fall &  rw_reg &  rs_reg & ~busy_int;
      start_clear = acc_instr & (op == OP_CLEAR);
      start_home  = acc_instr & (op == OP_HOME);
      // instruction 0x00 is refused: no busy period, only the error flag
      start_busy  = acc_data_wr |
                    (acc_instr & (op != OP_CLEAR) & (op != OP_HOME) & (op != OP_NULL));
      // status reads are always legal; writes and data reads are not while busy
      err_now     = (e_fall & ~rw_reg & busy_int) |
                    (e_fall & rw_reg & rs_reg & busy_int) |
                    (acc_instr & (op == OP_NULL));
      addr_step   = id_reg ? (addr_reg + 7'd1) : (addr_reg - 7'd1);
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE, ST_EHIGH: begin
            // a strobe can also arrive in IDLE if E rose while still busy
            if (start_clear) begin
               state_next = ST_CLEARING;
            end else if (start_home || start_busy) begin
               state_next = ST_BUSY;
            end else if (e_fall) begin
               state_next = ST_IDLE;
            end else if (e_rise) begin
               state_next = ST_EHIGH;
            end
         end
         ST_BUSY, ST_CLEARING: begin
            if (cnt_reg <= CW'(1)) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_reg          <= '0;
         addr_reg         <= 7'd0;
         id_reg           <= 1'b1;
         s_reg            <= 1'b0;
         disp_d_reg       <= 1'b0;
         disp_c_reg       <= 1'b0;
         disp_b_reg       <= 1'b0;
         fn_dl_reg        <= 1'b1;
         fn_n_reg         <= 1'b0;
         fn_f_reg         <= 1'b0;
         cgram_addr_reg   <= 6'd0;
         seen_func_reg    <= 1'b0;
         seen_disp_reg    <= 1'b0;
         seen_clear_reg   <= 1'b0;
         seen_entry_reg   <= 1'b0;
         init_done_reg    <= 1'b0;
         protocol_err_reg <= 1'b0;
         fill_active_reg  <= 1'b0;
         fill_idx_reg     <= 7'd0;
      end else begin
         // busy down-counter; starts only happen while not busy
         if (start_clear || start_home) begin
            cnt_reg <= CW'(CLEAR_CYCLES);
         end else if (start_busy) begin
            cnt_reg <= CW'(BUSY_CYCLES);
         end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CW'(1);
         end

         if (acc_instr) begin
            case (op)
               OP_CLEAR: begin
                  addr_reg       <= 7'd0;
                  id_reg         <= 1'b1;
                  seen_clear_reg <= 1'b1;
               end
               OP_HOME:  addr_reg <= 7'd0;
               OP_ENTRY: begin
                  id_reg         <= din_reg[1];
                  s_reg          <= din_reg[0];
                  seen_entry_reg <= 1'b1;
               end
               OP_DISP: begin
                  disp_d_reg    <= din_reg[2];
                  disp_c_reg    <= din_reg[1];
                  disp_b_reg    <= din_reg[0];
                  seen_disp_reg <= 1'b1;
               end
               OP_SHIFT: addr_reg <= din_reg[2] ? (addr_reg + 7'd1) : (addr_reg - 7'd1);
               OP_FUNC: begin
                  fn_dl_reg     <= din_reg[4];
                  fn_n_reg      <= din_reg[3];
                  fn_f_reg      <= din_reg[2];
                  seen_func_reg <= 1'b1;
               end
               OP_CGRAM: cgram_addr_reg <= din_reg[5:0];
               OP_DDRAM: addr_reg <= din_reg[6:0];
               default: ;
            endcase
         end else if (acc_data_wr || acc_data_rd) begin
            addr_reg <= addr_step;
         end

         if (seen_func_reg && seen_disp_reg && seen_clear_reg && seen_entry_reg) begin
            init_done_reg <= 1'b1;
         end

         if (err_now) begin
            protocol_err_reg <= 1'b1;
         end

         // clear fills one location per cycle; 128 cycles fit in CLEAR_CYCLES
         if (start_clear) begin
            fill_active_reg <= 1'b1;
            fill_idx_reg    <= 7'd0;
         end else if (fill_active_reg) begin
            fill_idx_reg <= fill_idx_reg + 7'd1;
            if (fill_idx_reg == 7'd127) begin
               fill_active_reg <= 1'b0;
            end
         end
      end
   end

   // ---------------------------------------------------------------- DDRAM
   // The fill and data writes never overlap: data writes are refused while busy.
   always_comb begin
      ram_we    = fill_active_reg | acc_data_wr;
      ram_waddr = fill_active_reg ? fill_idx_reg : addr_reg;
      ram_wdata = fill_active_reg ? 8'h20 : din_reg;
   end

   // contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ddram[ram_waddr] <= ram_wdata;
      end
      ram_q_reg <= ddram[addr_reg];
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      data_oe  = e_reg & rw_reg;
      data_out = 8'h00;
      if (data_oe) begin
         data_out = rs_reg ? ram_q_reg : {busy_int, addr_reg};
      end
   end

   assign busy         = busy_int;
   assign addr         = addr_reg;
   assign init_done    = init_done_reg;
   assign protocol_err = protocol_err_reg;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_lcd_bus_responder
//   Directed bench for lcd_bus_responder with default timing parameters.
//   Expected values are hand-computed constants for each step.
// -----------------------------------------------------------------------------
module tb_lcd_bus_responder;

   logic       clk;
   logic       reset_n;
   logic       E, RS, RW;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       data_oe, busy, init_done, protocol_err;
   logic [6:0] addr;

   int vectors     = 0;
   int miscompares = 0;

   lcd_bus_responder #(
      .BUSY_CYCLES  (40),
      .CLEAR_CYCLES (1600)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .E            (E),
      .RS           (RS),
      .RW           (RW),
      .data_in      (data_in),
      .data_out     (data_out),
      .data_oe      (data_oe),
      .busy         (busy),
      .addr         (addr),
      .init_done    (init_done),
      .protocol_err (protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one bus cycle: E high for three clocks, then E dropped (strobe follows)
   task automatic bus_cycle(input logic rs, input logic rw, input logic [7:0] d);
      @(negedge clk);
      RS = rs; RW = rw; data_in = d; E = 1'b1;
      repeat (3) @(negedge clk);
      E = 1'b0;
      $display("txn rs=%0b rw=%0b data=%02h", rs, rw, d);
   endtask

   // counts how many cycles busy stays high after a strobe (0 if it never rises)
   task automatic measure_busy(output int n);
      n = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (busy) n++;
         else if (n > 0 || i > 8) break;
      end
   endtask

   task automatic write_wait(input logic rs, input logic [7:0] d, output int n);
      bus_cycle(rs, 1'b0, d);
      measure_busy(n);
   endtask

   task automatic bus_read(input logic rs, output logic [7:0] d, output logic oe);
      @(negedge clk);
      RS = rs; RW = 1'b1; E = 1'b1;
      repeat (3) @(negedge clk);
      d  = data_out;
      oe = data_oe;
      E  = 1'b0;
      repeat (3) @(negedge clk);
      $display("txn read rs=%0b data_out=%02h oe=%0b", rs, d, oe);
   endtask

   initial begin
      int         n;
      logic [7:0] rd;
      logic       oe;

      E = 1'b0; RS = 1'b0; RW = 1'b0; data_in = 8'h00;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_busy", busy, 0);
      check("rst_addr", addr, 0);
      check("rst_oe", data_oe, 0);
      check("rst_dout", data_out, 8'h00);
      check("rst_init", init_done, 0);
      check("rst_perr", protocol_err, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // init sequence with busy durations
      write_wait(1'b0, 8'h38, n); check("busy_38", n, 40);
      write_wait(1'b0, 8'h0C, n); check("busy_0C", n, 40);
      write_wait(1'b0, 8'h01, n); check("busy_01", n, 1600);
      check("init_before_4th", init_done, 0);
      write_wait(1'b0, 8'h06, n); check("busy_06", n, 40);
      check("init_after_4th", init_done, 1);
      check("init_addr", addr, 0);
      check("init_perr", protocol_err, 0);

      // data writes and status reads
      write_wait(1'b0, 8'h80, n);
      write_wait(1'b1, 8'h41, n); check("busy_data", n, 40);
      write_wait(1'b1, 8'h42, n);
      check("addr_after_2", addr, 2);
      bus_read(1'b0, rd, oe);
      check("status_idle", rd, 8'h02);
      check("status_oe", oe, 1);
      check("oe_after_read", data_oe, 0);
      check("dout_after_read", data_out, 8'h00);
      write_wait(1'b0, 8'h80, n);
      bus_read(1'b1, rd, oe); check("ddram0", rd, 8'h41);
      check("addr_rd_adv1", addr, 1);
      bus_read(1'b1, rd, oe); check("ddram1", rd, 8'h42);
      check("addr_rd_adv2", addr, 2);
      bus_cycle(1'b0, 1'b0, 8'h82);
      bus_read(1'b0, rd, oe);
      check("status_busy", rd, 8'h82);
      measure_busy(n);
      check("perr_status_busy", protocol_err, 0);

      // address wrap 127 -> 0 and 0 -> 127
      write_wait(1'b0, 8'hFF, n); check("addr_127", addr, 127);
      write_wait(1'b1, 8'h55, n); check("wrap_up", addr, 0);
      write_wait(1'b0, 8'hFF, n);
      bus_read(1'b1, rd, oe); check("ddram127", rd, 8'h55);
      check("wrap_up_rd", addr, 0);
      write_wait(1'b0, 8'h04, n);
      write_wait(1'b0, 8'h80, n);
      write_wait(1'b1, 8'h66, n); check("wrap_down", addr, 127);
      write_wait(1'b0, 8'h14, n); check("shift_right", addr, 0);
      write_wait(1'b0, 8'h10, n); check("shift_left", addr, 127);
      write_wait(1'b0, 8'h80, n);
      bus_read(1'b1, rd, oe); check("ddram0_dec", rd, 8'h66);
      check("wrap_down_rd", addr, 127);
      write_wait(1'b0, 8'h06, n);

      // write during busy is refused
      bus_cycle(1'b0, 1'b0, 8'h02);
      bus_cycle(1'b1, 1'b0, 8'h41);
      measure_busy(n);
      check("perr_busy_wr", protocol_err, 1);
      check("home_addr", addr, 0);
      bus_read(1'b1, rd, oe); check("ignored_wr", rd, 8'h66);
      repeat (20) @(negedge clk);
      check("perr_sticky", protocol_err, 1);

      // full clear fills with spaces
      write_wait(1'b0, 8'h01, n); check("busy_clear2", n, 1600);
      bus_read(1'b1, rd, oe); check("clear_0", rd, 8'h20);
      write_wait(1'b0, 8'hFF, n);
      bus_read(1'b1, rd, oe); check("clear_127", rd, 8'h20);

      // reset in the middle of a clear
      write_wait(1'b0, 8'hE4, n);
      write_wait(1'b1, 8'h77, n); check("addr_101", addr, 101);
      bus_cycle(1'b0, 1'b0, 8'h01);
      for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
      repeat (50) @(negedge clk);
      check("busy_mid_clear", busy, 1);
      #2 reset_n = 1'b0;
      #1;
      check("mrst_busy", busy, 0);
      check("mrst_addr", addr, 0);
      check("mrst_oe", data_oe, 0);
      check("mrst_dout", data_out, 8'h00);
      check("mrst_init", init_done, 0);
      check("mrst_perr", protocol_err, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      write_wait(1'b0, 8'hE4, n);
      bus_read(1'b1, rd, oe); check("fill_abandoned", rd, 8'h77);
      write_wait(1'b0, 8'h80, n);
      bus_read(1'b1, rd, oe); check("fill_partial", rd, 8'h20);

      // instruction 0x00: error, no busy
      write_wait(1'b0, 8'h00, n);
      check("null_busy", n, 0);
      check("null_perr", protocol_err, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lcd_bus_responder.md
LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder

Interface
REQ-001 Parameter BUSY_CYCLES, default 40, clk cycles busy after any accepted instruction or data write except clear/home.
REQ-002 Parameter CLEAR_CYCLES, default 1600, clk cycles busy after clear display (0x01) or return home (0x02/0x03).
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port E  input  1  bus enable strobe from the LCD driver.
REQ-006 Port RS  input  1  0 = instruction/status, 1 = DDRAM data.
REQ-007 Port RW  input  1  0 = write, 1 = read.
REQ-008 Port data_in  input  8  bus data from driver.
REQ-009 Port data_out  output  8  read data returned to driver.
REQ-010 Port data_oe  output  1  high while data_out is valid (E high and RW=1).
REQ-011 Port busy  output  1  busy-flag state.
REQ-012 Port addr  output  7  current DDRAM address counter.
REQ-013 Port init_done  output  1  set once function set, display control, clear display and entry mode set have each been accepted.
REQ-014 Port protocol_err  output  1  sticky error flag.

Function
REQ-015 E, RS, RW, data_in SHALL be registered once; a falling edge of registered E SHALL be the write strobe; RS/RW/data_in SHALL be taken from the register stage at that edge.
REQ-016 Write strobe with RW=0 and busy=0 SHALL be accepted; with busy=1 it SHALL be ignored and protocol_err set.
REQ-017 Instruction decode (RS=0) by highest set bit: 0x01 clear (128-byte DDRAM filled with 0x20, addr=0, I/D=1); 0x02/0x03 home (addr=0); 0x04-0x07 entry mode (store I/D=bit1, S=bit0); 0x08-0x0F display control (store D,C,B); 0x10-0x1F cursor shift (bit2=1 increment addr, else decrement); 0x20-0x3F function set (store DL,N,F); 0x40-0x7F CGRAM set (stored, no other effect); 0x80-0xFF addr = data_in[6:0]; 0x00 SHALL set protocol_err and change nothing else.
REQ-018 Data write (RS=1) SHALL store data_in at DDRAM[addr], then addr +1 if I/D=1 else -1, modulo 128 (127->0, 0->127).
REQ-019 busy SHALL rise the cycle after an accepted write and stay high exactly BUSY_CYCLES cycles (CLEAR_CYCLES for clear/home) via a down-counter.
REQ-020 Clear SHALL complete its fill one location per cycle within CLEAR_CYCLES; CLEAR_CYCLES >= 128 is mandatory.
REQ-021 While registered E=1 and RW=1: RS=0 SHALL drive data_out={busy,addr}; RS=1 SHALL drive DDRAM[addr]; data_oe=1; otherwise data_out=0x00, data_oe=0.
REQ-022 A data read (RS=1,RW=1) SHALL advance addr per I/D on the E falling edge; status reads SHALL not change state; reads while busy SHALL set protocol_err (status reads excepted).
REQ-023 States: IDLE, EHIGH, BUSY, CLEARING; IDLE->EHIGH on E rise; EHIGH->BUSY/CLEARING on accepted write at E fall; EHIGH->IDLE on read or rejected write; BUSY/CLEARING->IDLE when counter reaches 0.
REQ-024 E rising edge during BUSY SHALL not alter the counter; status read remains serviced.
REQ-025 init_done SHALL be sticky until reset; order of the four instructions irrelevant.

Reset
REQ-026 reset_n low SHALL immediately force: state IDLE, busy=0, addr=0, I/D=1, S=0, D=C=B=0, DL=1, N=F=0, data_out=0x00, data_oe=0, init_done=0, protocol_err=0, counters 0.
REQ-027 DDRAM contents SHALL not be reset; reset mid-clear SHALL abandon the fill.
REQ-028 First E edge detection after reset_n release SHALL use registered E=0 as prior value.

Verification
REQ-029 Write 0x38,0x0C,0x01,0x06 each after busy clears -> init_done=1 after fourth, addr=0, busy high 40/1600/40/40 cycles respectively.
REQ-030 Write 0x80, data 0x41,0x42 -> DDRAM[0]=0x41, DDRAM[1]=0x42, addr=2; status read returns 0x02 when idle, 0x82 during busy.
REQ-031 Write 0xFF then data 0x55 with I/D=1 -> DDRAM[127]=0x55, addr wraps to 0; with 0x04 then 0x80 and data -> addr wraps 0->127.
REQ-032 Write 0x02 then immediately 0x41 during busy -> write ignored, protocol_err=1 and stays 1.
REQ-033 Assert reset_n low mid-clear at cycle 50 -> all outputs at REQ-026 values within same cycle, busy=0.
